// File: rtl/pic8259_pkg.sv
// Shared types and constants for the simplified 8259A interrupt controller.
package pic8259_pkg;

   typedef enum logic [1:0] {
      READY = 2'd0,
      ICW2  = 2'd1,
      ICW3  = 2'd2,
      ICW4  = 2'd3
   } init_state_t;

   localparam logic [2:0] OCW2_NSEOI = 3'b001;
   localparam logic [2:0] OCW2_SEOI  = 3'b011;
   localparam logic [2:0] SPUR_IR    = 3'd7;

endpackage

// File: rtl/pic8259_prio.sv
// Fixed-priority encoder: index of the lowest set bit (bit 0 wins), with a valid flag.
module pic8259_prio (
   input  logic [7:0] req_i,
   output logic [2:0] idx_o,
   output logic       vld_o
);

   always_comb begin
      idx_o = 3'd0;
      vld_o = |req_i;
      for (int i = 7; i >= 0; i--) begin
         if (req_i[i]) idx_o = 3'(i);
      end
   end

endmodule

// File: rtl/pic8259.sv
// Simplified 8259A: Wishbone-programmed at 0x20/0x21, edge-triggered IR0..IR7,
// fixed priority, single mode, normal or automatic EOI.
module pic8259
   import pic8259_pkg::*;
#(
   parameter logic [4:0] VEC_BASE_RST = 5'b00001
) (
   input  logic        wb_clk_i,
   input  logic        rst,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic [7:0]  irq_i,
   input  logic        inta_i,
   output logic        intr_o,
   output logic [7:0]  iid_o
);

   logic [7:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irq_prev_q;
   logic [4:0]  base_q, base_d;
   logic        aeoi_q, aeoi_d, need_icw4_q, need_icw4_d, single_q, single_d;
   logic        rd_isr_q, rd_isr_d, intr_q, intr_d;
   logic [7:0]  iid_q, iid_d;
   init_state_t state_q, state_d;

   logic [7:0] req;
   logic [2:0] req_p, isr_p;
   logic       req_vld, isr_vld;
   logic       wr_cmd, wr_dat;
   logic [7:0] cmd, dat;

   assign wb_ack_o = wb_stb_i & wb_cyc_i;
   assign wr_cmd   = wb_ack_o & wb_we_i & (wb_sel_i == 2'b01);
   assign wr_dat   = wb_ack_o & wb_we_i & (wb_sel_i == 2'b10);
   assign cmd      = wb_dat_i[7:0];
   assign dat      = wb_dat_i[15:8];
   assign req      = irr_q & ~imr_q;

   pic8259_prio u_req_prio (.req_i(req),   .idx_o(req_p), .vld_o(req_vld));
   pic8259_prio u_isr_prio (.req_i(isr_q), .idx_o(isr_p), .vld_o(isr_vld));

   always_comb begin
      case (wb_sel_i)
         2'b01:   wb_dat_o = {8'h00, rd_isr_q ? isr_q : irr_q};
         2'b10:   wb_dat_o = {imr_q, 8'h00};
         default: wb_dat_o = 16'h0000;
      endcase
   end

   // Update order fixes the same-cycle precedence: EOI clear, then inta,
   // then new edges (set beats inta clear), with ICW1 overriding everything.
   always_comb begin
      irr_d       = irr_q;
      isr_d       = isr_q;
      imr_d       = imr_q;
      base_d      = base_q;
      aeoi_d      = aeoi_q;
      need_icw4_d = need_icw4_q;
      single_d    = single_q;
      rd_isr_d    = rd_isr_q;
      state_d     = state_q;
      iid_d       = iid_q;
      intr_d      = req_vld & (~isr_vld | (req_p < isr_p));

      if (wr_cmd && cmd[4:3] == 2'b00) begin
         if (cmd[7:5] == OCW2_NSEOI && isr_vld) isr_d[isr_p] = 1'b0;
         else if (cmd[7:5] == OCW2_SEOI)        isr_d[cmd[2:0]] = 1'b0;
      end
      if (wr_cmd && cmd[4:3] == 2'b01 && cmd[1]) rd_isr_d = cmd[0];

      if (inta_i) begin
         if (req_vld) begin
            irr_d[req_p] = 1'b0;
            if (!aeoi_q) isr_d[req_p] = 1'b1;
            iid_d = {base_q, req_p};
         end else begin
            iid_d = {base_q, SPUR_IR};
         end
      end

      irr_d = irr_d | (irq_i & ~irq_prev_q);

      if (wr_dat) begin
         case (state_q)
            READY: imr_d = dat;
            ICW2: begin
               base_d  = dat[7:3];
               state_d = !single_q ? ICW3 : (need_icw4_q ? ICW4 : READY);
            end
            ICW3: state_d = need_icw4_q ? ICW4 : READY;
            ICW4: begin
               aeoi_d  = dat[1];
               state_d = READY;
            end
            default: state_d = READY;
         endcase
      end

      if (wr_cmd && cmd[4]) begin
         imr_d       = 8'h00;
         isr_d       = 8'h00;
         irr_d       = 8'h00;
         aeoi_d      = 1'b0;
         rd_isr_d    = 1'b0;
         need_icw4_d = cmd[0];
         single_d    = cmd[1];
         state_d     = ICW2;
      end
   end

   always_ff @(posedge wb_clk_i or posedge rst) begin
      if (rst) begin
         irr_q       <= 8'h00;
         isr_q       <= 8'h00;
         imr_q       <= 8'hFF;
         irq_prev_q  <= 8'h00;
         base_q      <= VEC_BASE_RST;
         aeoi_q      <= 1'b0;
         need_icw4_q <= 1'b0;
         single_q    <= 1'b0;
         rd_isr_q    <= 1'b0;
         state_q     <= READY;
         intr_q      <= 1'b0;
         iid_q       <= {VEC_BASE_RST, SPUR_IR};
      end else begin
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         irq_prev_q  <= irq_i;
         base_q      <= base_d;
         aeoi_q      <= aeoi_d;
         need_icw4_q <= need_icw4_d;
         single_q    <= single_d;
         rd_isr_q    <= rd_isr_d;
         state_q     <= state_d;
         intr_q      <= intr_d;
         iid_q       <= iid_d;
      end
   end

   assign intr_o = intr_q;
   assign iid_o  = iid_q;

endmodule

// File: tb/tb_pic8259.sv
// Directed bench for pic8259; expected values are queued as stimulus is issued.
module tb_pic8259;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic [7:0]  irq_i;
   logic        inta_i;
   logic        intr_o;
   logic [7:0]  iid_o;

   logic [15:0] exp_q[$];
   logic [15:0] rdv;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   pic8259 #(.VEC_BASE_RST(5'b00001)) dut (
      .wb_clk_i(clk), .rst(rst),
      .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .irq_i(irq_i), .inta_i(inta_i), .intr_o(intr_o), .iid_o(iid_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s observed=%h but scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic wr(input bit hi, input logic [7:0] d);
      wb_sel_i = hi ? 2'b10 : 2'b01;
      wb_dat_i = hi ? {d, 8'h00} : {8'h00, d};
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
      tick();
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      wb_sel_i = 2'b00; wb_dat_i = 16'h0000;
   endtask

   task automatic rd(input bit hi, output logic [15:0] v);
      wb_sel_i = hi ? 2'b10 : 2'b01;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0;
      #1;
      v = wb_dat_o;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_sel_i = 2'b00;
   endtask

   task automatic pulse_irq(input logic [7:0] m);
      irq_i = m;
      tick();
      irq_i = 8'h00;
   endtask

   task automatic ack();
      inta_i = 1'b1;
      tick();
      inta_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wb_sel_i = 2'b00; wb_dat_i = 16'h0000;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      irq_i = 8'h00; inta_i = 1'b0;
      #12 rst = 1'b0;

      // Reset state
      exp_q.push_back(16'h0000); chk("rst_intr", {15'd0, intr_o});
      exp_q.push_back(16'h000F); chk("rst_iid", {8'd0, iid_o});
      exp_q.push_back(16'hFF00); rd(1'b1, rdv); chk("rst_imr", rdv);
      wb_sel_i = 2'b01; wb_stb_i = 1'b1; wb_cyc_i = 1'b1; #1;
      exp_q.push_back(16'h0001); chk("ack_comb", {15'd0, wb_ack_o});
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_sel_i = 2'b00;
      pulse_irq(8'h01); tick(); tick();
      exp_q.push_back(16'h0000); chk("masked_intr", {15'd0, intr_o});

      // Init: single, ICW4, base 0x08, normal EOI
      wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h01); wr(1'b1, 8'h00);
      exp_q.push_back(16'h0000); rd(1'b1, rdv); chk("imr_clear", rdv);
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("irr_after_icw1", rdv);

      pulse_irq(8'h01);
      exp_q.push_back(16'h0000); chk("ir0_t1", {15'd0, intr_o});
      tick();
      exp_q.push_back(16'h0001); chk("ir0_t2", {15'd0, intr_o});
      ack();
      exp_q.push_back(16'h0008); chk("iid_ir0", {8'd0, iid_o});
      wr(1'b0, 8'h0B);
      exp_q.push_back(16'h0001); rd(1'b0, rdv); chk("isr_ir0", rdv);
      exp_q.push_back(16'h0000); chk("intr_drop", {15'd0, intr_o});
      wr(1'b0, 8'h20);
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("isr_eoi", rdv);

      // Simultaneous IR1 and IR3
      pulse_irq(8'h0A); tick();
      exp_q.push_back(16'h0001); chk("ir13_intr", {15'd0, intr_o});
      ack();
      exp_q.push_back(16'h0009); chk("iid_ir1", {8'd0, iid_o});
      tick(); tick();
      exp_q.push_back(16'h0000); chk("ir3_blocked", {15'd0, intr_o});
      exp_q.push_back(16'h0002); rd(1'b0, rdv); chk("isr_ir1", rdv);
      wr(1'b0, 8'h61); tick();
      exp_q.push_back(16'h0001); chk("ir3_intr", {15'd0, intr_o});
      ack();
      exp_q.push_back(16'h000B); chk("iid_ir3", {8'd0, iid_o});
      exp_q.push_back(16'h0008); rd(1'b0, rdv); chk("isr_ir3", rdv);
      wr(1'b0, 8'h20); tick();
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("isr_eoi3", rdv);
      exp_q.push_back(16'h0000); chk("idle_intr", {15'd0, intr_o});

      // Masked IR2 is latched but does not interrupt
      wr(1'b0, 8'h0A); wr(1'b1, 8'h04);
      pulse_irq(8'h04); tick(); tick();
      exp_q.push_back(16'h0000); chk("ir2_masked", {15'd0, intr_o});
      exp_q.push_back(16'h0004); rd(1'b0, rdv); chk("irr_ir2", rdv);
      wr(1'b1, 8'h00); tick();
      exp_q.push_back(16'h0001); chk("ir2_unmask", {15'd0, intr_o});
      ack();
      exp_q.push_back(16'h000A); chk("iid_ir2", {8'd0, iid_o});
      wr(1'b0, 8'h20);

      // Automatic EOI
      wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h03);
      pulse_irq(8'h20); tick();
      exp_q.push_back(16'h0001); chk("ir5_intr", {15'd0, intr_o});
      ack();
      exp_q.push_back(16'h000D); chk("iid_ir5", {8'd0, iid_o});
      wr(1'b0, 8'h0B);
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("isr_aeoi", rdv);
      tick();
      exp_q.push_back(16'h0000); chk("aeoi_intr", {15'd0, intr_o});

      // Spurious acknowledge
      ack();
      exp_q.push_back(16'h000F); chk("iid_spur", {8'd0, iid_o});
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("isr_spur", rdv);
      wr(1'b0, 8'h0A);
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("irr_spur", rdv);

      // Asynchronous reset mid-operation
      pulse_irq(8'h02); tick();
      exp_q.push_back(16'h0001); chk("ir1_pre_rst", {15'd0, intr_o});
      #2 rst = 1'b1; #1;
      exp_q.push_back(16'h0000); chk("arst_intr", {15'd0, intr_o});
      exp_q.push_back(16'h000F); chk("arst_iid", {8'd0, iid_o});
      exp_q.push_back(16'hFF00); rd(1'b1, rdv); chk("arst_imr", rdv);
      exp_q.push_back(16'h0000); rd(1'b0, rdv); chk("arst_irr", rdv);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
